// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage: one outstanding imem request at a time,
// fetched word handed to decode over a valid/ready handshake, flush redirect has priority.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    input  logic        inst_ready
);

    typedef enum logic [1:0] {StIdle, StFetch, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        discard_q, discard_d;

    // Low PC bits are always forced to zero on load.
    logic unused_low_bits;
    assign unused_low_bits = ^{next_pc[1:0], flush_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            inst_q    <= 32'h0;
            inst_pc_q <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        discard_d = discard_q;

        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (imem_gnt) begin
                    state_d   = StWait;
                    // A grant alongside a flush fetches the stale address; drop its data.
                    discard_d = flush;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    if (flush || discard_q) begin
                        state_d   = StFetch;
                        discard_d = 1'b0;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        state_d   = StHold;
                    end
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
            StHold: begin
                if (flush) begin
                    state_d = StFetch;
                end else if (inst_ready) begin
                    pc_d    = {next_pc[31:2], 2'b00};
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            pc_d = {flush_pc[31:2], 2'b00};
        end
    end

    assign imem_req   = (state_q == StFetch);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == StHold);
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign pc_plus4   = inst_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit against a transaction-level model with an
// outstanding-request queue and a deterministic instruction memory.
module tb_fetch_pc_unit;

    localparam logic [31:0] RstPc = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic        inst_ready;

    fetch_pc_unit #(.RESET_PC(RstPc)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_pc    (next_pc),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .pc_plus4   (pc_plus4),
        .inst_ready (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: started/requesting/holding flags plus a queue of granted addresses.
    bit          m_started;
    bit          m_req;
    bit          m_valid;
    bit          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_inst_pc;
    logic [31:0] m_inst;
    logic [31:0] outst[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_req     = 1'b0;
        m_valid   = 1'b0;
        m_drop    = 1'b0;
        m_pc      = RstPc;
        m_inst_pc = RstPc;
        m_inst    = 32'h0;
        outst.delete();
    endtask

    task automatic check_outputs();
        check("imem_req", 32'(imem_req), 32'(m_req));
        check("imem_addr", imem_addr, m_pc);
        check("inst_valid", 32'(inst_valid), 32'(m_valid));
        check("inst", inst, m_inst);
        check("inst_pc", inst_pc, m_inst_pc);
        check("pc_plus4", pc_plus4, m_inst_pc + 32'd4);
    endtask

    // Entered at a negedge: check, drive, advance the model, return at the next negedge.
    task automatic step(input bit gnt, input bit rvalid, input bit ready, input bit fl,
                        input logic [31:0] fpc, input logic [31:0] npc);
        logic [31:0] a;
        check_outputs();
        imem_gnt    = gnt;
        imem_rvalid = rvalid;
        imem_rdata  = (outst.size() != 0) ? mem_word(outst[0]) : $urandom;
        inst_ready  = ready;
        flush       = fl;
        flush_pc    = fpc;
        next_pc     = npc;

        if (!m_started) begin
            m_started = 1'b1;
            m_req     = 1'b1;
        end else if (m_req) begin
            if (gnt) begin
                outst.push_back(m_pc);
                m_drop = fl;
                m_req  = 1'b0;
            end
        end else if (outst.size() != 0) begin
            if (rvalid) begin
                a = outst.pop_front();
                if (m_drop || fl) begin
                    m_req  = 1'b1;
                    m_drop = 1'b0;
                end else begin
                    m_inst    = mem_word(a);
                    m_inst_pc = a;
                    m_valid   = 1'b1;
                end
            end else if (fl) begin
                m_drop = 1'b1;
            end
        end else if (m_valid) begin
            if (fl) begin
                m_valid = 1'b0;
                m_req   = 1'b1;
            end else if (ready) begin
                m_valid = 1'b0;
                m_req   = 1'b1;
                m_pc    = npc & ~32'd3;
            end
        end
        if (fl) m_pc = fpc & ~32'd3;

        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        inst_ready  = 1'b0;
        flush       = 1'b0;
        flush_pc    = 32'h0;
        next_pc     = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Full-speed sequential fetch.
        for (int i = 0; i < 9; i++) step(1, 1, 1, 0, 32'h0, m_inst_pc + 32'd4);

        // Backpressure, then branch with misaligned target.
        for (int i = 0; i < 8; i++) begin
            if (m_valid) break;
            step(1, 1, 0, 0, 32'h0, 32'h0);
        end
        check("reach_hold", 32'(inst_valid), 32'd1);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 32'h0, 32'h0);
        step(0, 0, 1, 0, 32'h0, 32'h0000_0103);
        check("branch_addr", imem_addr, 32'h0000_0100);

        // Flush while waiting for data: late response dropped.
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 1, 32'h0000_0040, 32'h0);
        step(0, 1, 0, 0, 32'h0, 32'h0);
        check("wait_flush_valid", 32'(inst_valid), 32'd0);
        check("wait_flush_addr", imem_addr, 32'h0000_0040);

        // Flush in HOLD beats the simultaneous accept.
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(0, 1, 0, 0, 32'h0, 32'h0);
        step(0, 0, 1, 1, 32'h0000_0200, 32'h0000_0080);
        check("hold_flush_valid", 32'(inst_valid), 32'd0);
        check("hold_flush_addr", imem_addr, 32'h0000_0200);

        // pc_plus4 wraps at the top of the address space.
        step(0, 0, 0, 1, 32'hFFFF_FFFF, 32'h0);
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(0, 1, 0, 0, 32'h0, 32'h0);
        check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        step(0, 0, 1, 0, 32'h0, 32'h0000_0010);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] fpc;
            logic [31:0] npc;
            fpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
            npc = ($urandom_range(0, 1) == 1) ? m_inst_pc + 32'd4 : $urandom;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), fpc, npc);
        end

        // Asynchronous reset in the middle of WAIT.
        for (int i = 0; i < 20; i++) begin
            if (outst.size() != 0) break;
            step(1, 0, 1, 0, 32'h0, m_inst_pc + 32'd4);
        end
        check("reach_wait", 32'(outst.size() != 0 && !m_req && !m_valid), 32'(!imem_req && !inst_valid));
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_1234;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_valid", 32'(inst_valid), 32'd0);
        check("arst_inst", inst, 32'h0);
        check("arst_inst_pc", inst_pc, RstPc);
        check("arst_pc_plus4", pc_plus4, RstPc + 32'd4);
        check("arst_addr", imem_addr, RstPc);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 0, 32'h0, 32'h0);
        check("post_reset_addr", imem_addr, RstPc);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 32'h0, m_inst_pc + 32'd4);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
